// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that puts the I-cache and D-cache miss controllers onto one
// pipelined main memory, holding the grant for a whole burst and routing read data back to its issuer.
module mem_arbiter #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int READ_LATENCY    = 4,
    parameter int MAX_OUTSTANDING = READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic                  i_wr,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  i_gnt,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_rvalid,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_rvalid,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DRAIN} state_t;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    state_t                state, state_next;
    logic [CW-1:0]         count, count_next;
    logic                  owner, owner_next;           // 1 = D-cache
    logic                  last_owner, last_owner_next;
    logic                  granted, full, issue, retire;
    logic                  x_req, x_wr;
    logic [ADDR_WIDTH-1:0] x_addr;
    logic [DATA_WIDTH-1:0] x_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            owner      <= 1'b1;
            last_owner <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            owner      <= owner_next;
            last_owner <= last_owner_next;
        end
    end

    assign granted = state == GRANT_I || state == GRANT_D;
    assign x_req   = state == GRANT_D ? d_req : i_req;
    assign x_wr    = state == GRANT_D ? d_wr : i_wr;
    assign x_addr  = state == GRANT_D ? d_addr : i_addr;
    assign x_wdata = state == GRANT_D ? d_wdata : i_wdata;
    // a return in the same cycle frees a slot, so a full pipeline keeps issuing
    assign full       = count == CW'(MAX_OUTSTANDING) && !mem_rvalid;
    assign issue      = mem_enable && !mem_wr;
    assign retire     = mem_rvalid && count != '0;
    assign count_next = count + CW'(issue) - CW'(retire);

    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_owner_next = last_owner;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || !last_owner)) begin
                    state_next = GRANT_D;
                    owner_next = 1'b1;
                end else if (i_req) begin
                    state_next = GRANT_I;
                    owner_next = 1'b0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (!x_req) begin
                    state_next      = (count == '0 && !issue) ? IDLE : DRAIN;
                    last_owner_next = state == GRANT_D;
                end
            end
            DRAIN: state_next = count_next == '0 ? IDLE : DRAIN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        i_gnt      = state == GRANT_I;
        d_gnt      = state == GRANT_D;
        i_ready    = i_gnt && !full;
        d_ready    = d_gnt && !full;
        mem_enable = granted && x_req && !full;
        mem_wr     = mem_enable && x_wr;
        mem_addr   = granted ? {x_addr[ADDR_WIDTH-1:1], 1'b0} : '0;
        mem_wdata  = granted ? x_wdata : '0;
        i_rvalid   = retire && !owner;
        d_rvalid   = retire && owner;
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
endmodule
